// File: rtl/sched_pkg.sv
// sched_pkg: shared state type and default constants for the audio sample scheduler.
package sched_pkg;
    typedef enum logic [1:0] {IDLE, PRIMING, RUNNING} state_t;
    localparam int DEF_DIV = 750;
    localparam int DEF_DATA_W = 14;
    localparam int DEF_FIFO_AW = 4;
    localparam int DEF_PRIME_LEVEL = 8;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: single-clock first-word-fall-through FIFO with synchronous flush.
module sample_fifo
    import sched_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int AW = DEF_FIFO_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level
);
    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);
    logic [DATA_W-1:0] mem [2**AW];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = level == DEPTH;
    assign empty = level == '0;
    assign do_pop = pop && !empty;
    // a pop frees the slot this push needs, so full+pop+push is accepted
    assign do_push = push && (!full || do_pop);
    assign rdata = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/audio_sample_scheduler.sv
// audio_sample_scheduler: sample-rate pacing of ADC starts and jitter-buffered DAC playback.
// Define SCHED_LOOPBACK_EN to add loopback_i, which feeds ADC results into the DAC FIFO.
module audio_sample_scheduler
    import sched_pkg::*;
#(
    parameter int DIV = DEF_DIV,
    parameter int DATA_W = DEF_DATA_W,
    parameter int FIFO_AW = DEF_FIFO_AW,
    parameter int PRIME_LEVEL = DEF_PRIME_LEVEL
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               enable_i,
    input  logic               clear_flags_i,
`ifdef SCHED_LOOPBACK_EN
    input  logic               loopback_i,
`endif
    output logic               adc_start_o,
    input  logic               adc_busy_i,
    input  logic [DATA_W-1:0]  adc_data_i,
    input  logic               adc_data_rdy_i,
    output logic [DATA_W-1:0]  sample_data_o,
    output logic               sample_rdy_o,
    input  logic [DATA_W-1:0]  dac_in_data_i,
    input  logic               dac_in_rdy_i,
    output logic [DATA_W-1:0]  dac_data_o,
    output logic               dac_data_rdy_o,
    output logic [FIFO_AW:0]   fifo_level_o,
    output logic               underrun_o,
    output logic               overrun_o,
    output logic               adc_miss_o
);
    localparam logic [15:0] LAST = 16'(DIV - 1);
    localparam logic [FIFO_AW:0] PRIME = (FIFO_AW+1)'(PRIME_LEVEL);
    state_t state, state_nx;
    logic [15:0] cnt;
    logic tick, src_rdy, wr, pop, starve, empty, full;
    logic [DATA_W-1:0] src_data, head;
`ifdef SCHED_LOOPBACK_EN
    assign src_rdy = loopback_i ? adc_data_rdy_i : dac_in_rdy_i;
    assign src_data = loopback_i ? adc_data_i : dac_in_data_i;
`else
    assign src_rdy = dac_in_rdy_i;
    assign src_data = dac_in_data_i;
`endif
    assign tick = enable_i && cnt == LAST;
    assign wr = src_rdy && state != IDLE;
    assign starve = tick && state == RUNNING && empty;
    assign pop = tick && (state == RUNNING ? !empty : state == PRIMING && fifo_level_o >= PRIME);

    sample_fifo #(.DATA_W(DATA_W), .AW(FIFO_AW)) u_fifo (
        .clk(clk_i),
        .rst_n(reset_ni),
        .flush(state == IDLE),
        .push(wr),
        .wdata(src_data),
        .pop(pop),
        .rdata(head),
        .full(full),
        .empty(empty),
        .level(fifo_level_o)
    );

    always_comb begin
        state_nx = state;
        if (!enable_i) state_nx = IDLE;
        else if (state == IDLE) state_nx = PRIMING;
        else if (state == PRIMING && pop) state_nx = RUNNING;
        else if (starve) state_nx = PRIMING;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state <= IDLE;
            cnt <= '0;
            adc_start_o <= 1'b0;
            sample_rdy_o <= 1'b0;
            sample_data_o <= '0;
            dac_data_o <= '0;
            dac_data_rdy_o <= 1'b0;
            underrun_o <= 1'b0;
            overrun_o <= 1'b0;
            adc_miss_o <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= (!enable_i || tick) ? '0 : cnt + 16'd1;
            adc_start_o <= tick && !adc_busy_i;
            sample_rdy_o <= adc_data_rdy_i;
            sample_data_o <= adc_data_i;
            // a starved tick still strobes the DAC, replaying the held sample
            dac_data_rdy_o <= pop || starve;
            if (pop) dac_data_o <= head;
            underrun_o <= starve || (underrun_o && !clear_flags_i);
            overrun_o <= (wr && full && !pop) || (overrun_o && !clear_flags_i);
            adc_miss_o <= (tick && adc_busy_i) || (adc_miss_o && !clear_flags_i);
        end
    end
endmodule

// File: doc/audio_sample_scheduler.md
Name: audio_sample_scheduler

Overview:
- Paces the audio datapath at a fixed sample rate from the 36 MHz system clock.
- Issues conversion-start strobes to the successive-approximation ADC and forwards its results to the host interface.
- Buffers host-supplied DAC samples in a jitter FIFO and releases exactly one sample per sample tick to the DAC shift-out block, decoupling DAC timing from USB burst arrival.

Parameters:
- DIV, 750, system clocks per sample period (36 MHz / 750 = 48 kHz); legal range 16..65535.
- DATA_W, 14, sample width in bits.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16.
- PRIME_LEVEL, 8, FIFO occupancy required before DAC playback starts; legal range 1..depth.

Ports:
- clk_i  in  1  system clock, 36 MHz.
- reset_ni  in  1  synchronous reset, active-low.
- enable_i  in  1  run control; low = stopped and flushed.
- clear_flags_i  in  1  one-cycle pulse; clears sticky error flags.
- adc_start_o  out  1  one-cycle conversion-start strobe to the ADC.
- adc_busy_i  in  1  ADC conversion in progress.
- adc_data_i  in  DATA_W  ADC result.
- adc_data_rdy_i  in  1  one-cycle ADC result valid.
- sample_data_o  out  DATA_W  ADC sample to the host interface.
- sample_rdy_o  out  1  one-cycle valid for sample_data_o.
- dac_in_data_i  in  DATA_W  DAC sample from the host interface.
- dac_in_rdy_i  in  1  one-cycle write strobe for dac_in_data_i.
- dac_data_o  out  DATA_W  sample to the DAC shift-out block.
- dac_data_rdy_o  out  1  one-cycle load strobe to the DAC shift-out block.
- fifo_level_o  out  FIFO_AW+1  current FIFO occupancy.
- underrun_o  out  1  sticky: tick arrived while FIFO empty in RUNNING.
- overrun_o  out  1  sticky: write attempted while FIFO full.
- adc_miss_o  out  1  sticky: tick arrived while adc_busy_i high.

Behaviour:
- Reset (reset_ni low at a clk_i edge): every output 0, tick counter 0, FIFO empty, state IDLE.
- Tick counter:
  - Counts 0..DIV-1 while enable_i is high; tick asserts for one cycle when the count equals DIV-1, then the count wraps to 0.
  - enable_i low holds the count at 0. The first tick occurs DIV cycles after enable_i rises.
- ADC path:
  - On a tick with adc_busy_i low, adc_start_o pulses in the following cycle.
  - On a tick with adc_busy_i high, there is no strobe and adc_miss_o sets.
  - adc_data_rdy_i is registered to sample_rdy_o and adc_data_i to sample_data_o (1-cycle latency, independent of state).
- FIFO:
  - A write on dac_in_rdy_i is accepted unless the FIFO is full. A write to a full FIFO is dropped and sets overrun_o.
  - A simultaneous pop and push while full are both accepted; level is unchanged.
  - A simultaneous pop and push while empty: the pop sees empty, the push is accepted.
- State machine:
  - IDLE: FIFO flushed, writes ignored. enable_i high -> PRIMING.
  - PRIMING: writes accepted, no pops. fifo_level_o >= PRIME_LEVEL at a tick -> RUNNING, and that tick performs the first pop.
  - RUNNING: each tick pops one entry; dac_data_o updates and dac_data_rdy_o pulses 1 cycle after the tick. A tick with the FIFO empty sets underrun_o, pulses dac_data_rdy_o with the held previous dac_data_o, and goes to PRIMING.
  - Any state: enable_i low -> IDLE next cycle. dac_data_o retains its last value; an in-flight strobe is still emitted.
- Sticky flags: cleared only by reset or clear_flags_i. If a set event and clear_flags_i occur in the same cycle, set wins.
- fifo_level_o is registered and reflects pushes and pops one cycle after they occur.

Optional Feature:
- SCHED_LOOPBACK_EN defined:
  - Adds input port loopback_i (1 bit).
  - While loopback_i is high, the FIFO write source is adc_data_i / adc_data_rdy_i instead of dac_in_*, and host writes are ignored.
  - sample_rdy_o still forwards to the host.
- Undefined: no loopback_i port; the FIFO is fed only from dac_in_*.

Decomposition:
- Package sched_pkg: state enum (IDLE, PRIMING, RUNNING), default DATA_W, DIV and FIFO_AW constants.
- One sub-module, sample_fifo: synchronous single-clock FIFO with push, pop, full, empty and level outputs, plus a synchronous flush input.

Test Plan:
- DIV=10, enable high, adc_busy_i low -> adc_start_o pulses at cycles 10, 20, 30 after enable; adc_data_rdy_i with 0x1ABC -> sample_rdy_o plus 0x1ABC one cycle later.
- PRIME_LEVEL=8: write 0x0001..0x0008 -> no dac_data_rdy_o until level reaches 8, then at the next tick outputs in order 0x0001, 0x0002, … one per tick.
- Stop writes in RUNNING: after the FIFO drains, the next tick re-emits the last value, underrun_o=1 and state is PRIMING; clear_flags_i -> underrun_o=0.
- 17 writes with enable high and no ticks -> level 16, overrun_o=1, the 17th value is never output.
- adc_busy_i held high across a tick -> no adc_start_o, adc_miss_o=1. Drop enable_i mid-RUNNING -> IDLE, level 0, the counter restarts from 0 on re-enable.
- SCHED_LOOPBACK_EN, loopback_i=1: ADC results 0x0100..0x0107 -> after priming, dac_data_o replays 0x0100..0x0107 in order.
